// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared helpers for the carry-segmented pipelined adder.
//   calc_stages  - number of SEG_W-bit pipeline stages for a WIDTH-bit adder
//   cfg_legal    - 1 when WIDTH/SEG_W describe a buildable adder
// Optional feature macro used by importers: PIPE_ADDER_SUB_EN (adds a subtract input).
package pipe_adder_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_SEG_W = 8;

    // Clamped to >= 1 so an illegal configuration still elaborates far enough to
    // reach the explicit configuration error in the top level.
    function automatic int unsigned calc_stages(int unsigned width, int unsigned seg_w);
        int unsigned n;
        n = (seg_w == 0) ? 1 : width / seg_w;
        return (n == 0) ? 1 : n;
    endfunction

    function automatic bit cfg_legal(int unsigned width, int unsigned seg_w);
        return (seg_w >= 1) && (width >= seg_w) && ((width % seg_w) == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_seg.sv
// pipe_adder_seg: one pipeline stage of pipe_adder.
//   Adds one SEG_W-bit slice plus an incoming carry and registers the result slice,
//   the carry out of the slice, the signed-overflow flag of the slice MSB and the
//   stage valid bit. All registers load only when en (pipeline advance) is high.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en                pipeline advance; registers hold when low
//   valid_in          valid bit of the slot entering this stage
//   a, b, carry_in    slice operands and carry from the previous stage
//   valid             registered valid bit
//   sum               registered result slice
//   carry             registered carry out of the slice MSB
//   ovf               registered (carry into MSB) ^ (carry out of MSB)
module pipe_adder_seg
    import pipe_adder_pkg::*;
#(
    parameter int unsigned SEG_W = DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             valid_in,
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             carry_in,
    output logic             valid,
    output logic [SEG_W-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    logic [SEG_W:0]   raw;
    logic             carry_msb;

    logic             valid_q;
    logic [SEG_W-1:0] sum_q;
    logic             carry_q;
    logic             ovf_q;

    always_comb begin
        raw       = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, carry_in};
        // Carry into the MSB recovered from the MSB sum bit; works for SEG_W == 1 too.
        carry_msb = raw[SEG_W-1] ^ a[SEG_W-1] ^ b[SEG_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (en) begin
            valid_q <= valid_in;
            sum_q   <= raw[SEG_W-1:0];
            carry_q <= raw[SEG_W];
            ovf_q   <= carry_msb ^ raw[SEG_W];
        end
    end

    assign valid = valid_q;
    assign sum   = sum_q;
    assign carry = carry_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: parametrised carry-segmented pipelined adder, sum = a + b + cin.
//   One SEG_W-bit slice is added per stage; the carry ripples between stages through
//   registers. Valid/ready handshake on both sides with a global stall: the whole
//   pipe advances or holds as one. Latency STAGES = WIDTH / SEG_W cycles.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    input handshake for a, b, cin (and sub)
//   a, b, cin             operands and carry in
//   sub                   (PIPE_ADDER_SUB_EN only) 1: compute a - b, cin ignored
//   out_valid, out_ready  output handshake for sum, cout, ovf
//   sum                   (a + b + cin) mod 2^WIDTH
//   cout                  carry out of bit WIDTH-1 (for subtract: 1 = no borrow)
//   ovf                   signed overflow
// Configuration macro: PIPE_ADDER_SUB_EN.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SEG_W = DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = calc_stages(WIDTH, SEG_W);

    if (!cfg_legal(WIDTH, SEG_W)) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a nonzero multiple of SEG_W (SEG_W >= 1)");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Per-stage views: operands entering stage k (next slice in the low bits),
    // completed low result slices entering stage k, and the stage outputs.
    logic [STAGES-1:0][WIDTH-1:0] opa;
    logic [STAGES-1:0][WIDTH-1:0] opb;
    logic [STAGES-1:0][WIDTH-1:0] lo;
    logic [STAGES-1:0][WIDTH-1:0] sum_full;
    logic [STAGES-1:0][SEG_W-1:0] seg_sum;
    logic [STAGES-1:0]            seg_valid;
    logic [STAGES-1:0]            seg_carry;
    logic [STAGES-1:0]            seg_ovf;

    // A full output slot only moves when downstream takes it.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

`ifdef PIPE_ADDER_SUB_EN
    // a - b == a + ~b + 1; the inversion happens once, before stage 0.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic seg_cin;
        logic seg_vin;

        if (k == 0) begin : g_first
            assign opa[k]  = a;
            assign opb[k]  = b_eff;
            assign lo[k]   = '0;
            assign seg_cin = cin_eff;
            assign seg_vin = in_valid;
        end else begin : g_next
            logic [WIDTH-1:0] opa_q;
            logic [WIDTH-1:0] opb_q;
            logic [WIDTH-1:0] lo_q;

            // Bubbles advance too; their data is don't-care, only valid matters.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    opa_q <= '0;
                    opb_q <= '0;
                    lo_q  <= '0;
                end else if (advance) begin
                    opa_q <= opa[k-1] >> SEG_W;
                    opb_q <= opb[k-1] >> SEG_W;
                    lo_q  <= sum_full[k-1];
                end
            end

            assign opa[k]  = opa_q;
            assign opb[k]  = opb_q;
            assign lo[k]   = lo_q;
            assign seg_cin = seg_carry[k-1];
            assign seg_vin = seg_valid[k-1];
        end

        pipe_adder_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (advance),
            .valid_in (seg_vin),
            .a        (opa[k][SEG_W-1:0]),
            .b        (opb[k][SEG_W-1:0]),
            .carry_in (seg_cin),
            .valid    (seg_valid[k]),
            .sum      (seg_sum[k]),
            .carry    (seg_carry[k]),
            .ovf      (seg_ovf[k])
        );

        // Merge this stage's freshly registered slice above the earlier ones.
        assign sum_full[k] = lo[k] | (WIDTH'(seg_sum[k]) << (k * SEG_W));
    end

    assign out_valid = seg_valid[STAGES-1];
    assign sum       = sum_full[STAGES-1];
    assign cout      = seg_carry[STAGES-1];
    assign ovf       = seg_ovf[STAGES-1];

    // Last-stage operand upper bits and inner-stage overflow flags have no consumer.
    logic unused_bits;
    assign unused_bits = ^{opa[STAGES-1], opb[STAGES-1], seg_ovf};

endmodule

// File: tb/tb_pipe_adder.sv
module tb_pipe_adder;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned SEG_W  = 8;
    localparam int unsigned STAGES = WIDTH / SEG_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        sub_r = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    always #5 clk = ~clk;

    pipe_adder #(
        .WIDTH (WIDTH),
        .SEG_W (SEG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef PIPE_ADDER_SUB_EN
        .sub       (sub_r),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int unsigned stamp;
        bit          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    bit          rnd_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference: plain wide arithmetic on the whole word.
    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                   input logic ci, input logic sb);
        exp_t        e;
        logic [31:0] bb;
        logic [32:0] full;
        bb     = sb ? ~bv : bv;
        full   = {1'b0, av} + {1'b0, bb} + {32'd0, (sb ? 1'b1 : ci)};
        e.sum  = full[31:0];
        e.cout = full[32];
        e.ovf  = (av[31] == bb[31]) && (full[31] != av[31]);
        e.stamp = 0;
        e.lat  = 1'b0;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the item was accepted.
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                        input logic sb, input bit lat);
        exp_t e;
        int   n;
        a = av; b = bv; cin = ci; sub_r = sb; in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) break;
        end
        if (n > 200) begin
            n_vec++; n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 200 cycles");
        end else begin
            e = model(av, bv, ci, sb);
            e.stamp = cyc;
            e.lat = lat;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: pops expected results whenever the DUT hands one over.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL spurious_output: got sum=%h, required no output", sum);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {30'd0, sum, cout, ovf}, {30'd0, e.sum, e.cout, e.ovf});
                    if (e.lat) check("latency", 64'(cyc - e.stamp), 64'(STAGES));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;

        // Reset state
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_flags", 64'({cout, ovf}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed: cross-slice carry, full ripple, signed overflow both ways
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        drain();

        // Back-to-back random, no backpressure: latency checked per item
        for (int i = 0; i < 16; i++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        drain();

        // Full pipe stalled for 5 cycles
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        @(negedge clk);
        held = sum;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_sum_stable", 64'(sum), 64'(held));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Reset with items in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send($urandom, $urandom, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("preflush_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_sum", 64'(sum), 64'd0);
        check("flush_flags", 64'({cout, ovf}), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_stale_output", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;

`ifdef PIPE_ADDER_SUB_EN
        send(32'd5, 32'd7, 1'b0, 1'b1, 1'b1);
        send(32'd7, 32'd5, 1'b1, 1'b1, 1'b1);
        send(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b1);
        drain();
`endif

        // Random traffic under random backpressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
`ifdef PIPE_ADDER_SUB_EN
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
`else
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
`endif
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rnd_ready = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
